// File: rtl/miner_nonce_scheduler.sv
// Nonce batch scheduler for an array of sha3_256_miner cores sharing one job.
// Batches of 2^BATCH_LOG2 nonces go round-robin to idle cores. The first
// reported solution is latched, all cores are aborted and irq pulses once.
module miner_nonce_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int BATCH_LOG2 = 16,
    parameter int NONCE_W    = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    input  logic [NONCE_W-1:0]           start_nonce,
    input  logic [NUM_CORES-1:0]         core_ready,
    input  logic [NUM_CORES-1:0]         core_found,
    input  logic [NUM_CORES*NONCE_W-1:0] core_solution,
    output logic [NUM_CORES-1:0]         core_load,
    output logic [NONCE_W-1:0]           core_base,
    output logic                         core_abort,
    output logic [NONCE_W-1:0]           solution,
    output logic                         found,
    output logic                         running,
    output logic                         exhausted,
    output logic [NONCE_W-1:0]           next_nonce,
    output logic                         irq
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    // One extra bit so the carry out of the nonce space is visible.
    localparam logic [NONCE_W:0] BATCH_INC = (NONCE_W + 1)'(1) << BATCH_LOG2;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t               state, state_nxt;
    logic                 run_d;
    logic                 armed;
    logic [IDX_W-1:0]     rr_ptr, rr_nxt;
    logic [NUM_CORES-1:0] last_grant;

    logic                 start;
    logic [NUM_CORES-1:0] eligible;
    logic [IDX_W-1:0]     grant, winner;
    logic [NONCE_W:0]     nonce_inc;

    logic [NUM_CORES-1:0] load_nxt;
    logic [NONCE_W-1:0]   base_nxt, sol_nxt, nonce_nxt;
    logic                 abort_nxt, irq_nxt, found_nxt, exh_nxt;

    // First requesting index at or after ptr, wrapping; smallest circular distance wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        int best;
        int d;
        pick = ptr;
        best = NUM_CORES;
        for (int i = 0; i < NUM_CORES; i++) begin
            d = i - int'(ptr);
            if (d < 0) d = d + NUM_CORES;
            if (req[i] && d < best) begin
                best = d;
                pick = IDX_W'(i);
            end
        end
        return pick;
    endfunction

    // Successor index modulo NUM_CORES.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        if (int'(idx) >= NUM_CORES - 1) return '0;
        return idx + 1'b1;
    endfunction

    // Solution slice belonging to core idx.
    function automatic logic [NONCE_W-1:0] core_slice(input logic [NUM_CORES*NONCE_W-1:0] sols,
                                                      input logic [IDX_W-1:0] idx);
        logic [NONCE_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (int'(idx) == i) s = sols[i*NONCE_W +: NONCE_W];
        end
        return s;
    endfunction

    // A run level already high when reset releases is not an edge: armed gates it.
    assign start     = run & ~run_d & armed;
    // A core just loaded may still show ready for one cycle, so it is masked.
    assign eligible  = core_ready & ~last_grant;
    assign grant     = rr_pick(eligible, rr_ptr);
    assign winner    = rr_pick(core_found, rr_ptr);
    assign nonce_inc = {1'b0, next_nonce} + BATCH_INC;
    assign running   = (state == DISPATCH) || (state == DRAIN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and next-output decode; abort/found outrank dispatch.
    always_comb begin
        state_nxt = state;
        load_nxt  = '0;
        base_nxt  = core_base;
        abort_nxt = 1'b0;
        irq_nxt   = 1'b0;
        found_nxt = found;
        exh_nxt   = exhausted;
        sol_nxt   = solution;
        nonce_nxt = next_nonce;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                if (start) begin
                    nonce_nxt = start_nonce;
                    found_nxt = 1'b0;
                    exh_nxt   = 1'b0;
                    state_nxt = DISPATCH;
                end
            end
            DISPATCH, DRAIN: begin
                if (!run) begin
                    abort_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (|core_found) begin
                    sol_nxt   = core_slice(core_solution, winner);
                    found_nxt = 1'b1;
                    irq_nxt   = 1'b1;
                    abort_nxt = 1'b1;
                    state_nxt = DONE;
                end else if (state == DISPATCH) begin
                    if (|eligible) begin
                        load_nxt  = NUM_CORES'(1) << grant;
                        base_nxt  = next_nonce;
                        rr_nxt    = rr_next(grant);
                        nonce_nxt = nonce_inc[NONCE_W-1:0];
                        // Carry out means the batch just issued was the last one.
                        if (nonce_inc[NONCE_W]) state_nxt = DRAIN;
                    end
                end else if ((&core_ready) && (last_grant == '0)) begin
                    exh_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                if (!run) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs and scheduler bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_d      <= 1'b0;
            armed      <= 1'b0;
            rr_ptr     <= '0;
            last_grant <= '0;
            core_load  <= '0;
            core_base  <= '0;
            core_abort <= 1'b0;
            irq        <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            solution   <= '0;
            next_nonce <= '0;
        end else begin
            run_d      <= run;
            armed      <= 1'b1;
            rr_ptr     <= rr_nxt;
            last_grant <= load_nxt;
            core_load  <= load_nxt;
            core_base  <= base_nxt;
            core_abort <= abort_nxt;
            irq        <= irq_nxt;
            found      <= found_nxt;
            exhausted  <= exh_nxt;
            solution   <= sol_nxt;
            next_nonce <= nonce_nxt;
        end
    end

endmodule

// File: tb/tb_miner_nonce_scheduler.sv
// Self-checking bench for miner_nonce_scheduler: a 4-core instance and a
// 1-core instance, both with 16-nonce batches.
module tb_miner_nonce_scheduler;

    localparam int N  = 4;
    localparam int BL = 4;
    localparam int W  = 64;
    localparam logic [W-1:0] BATCH = 64'd16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4-core instance
    logic           run = 1'b0;
    logic [W-1:0]   start_nonce = '0;
    logic [N-1:0]   core_ready = '0, core_found = '0;
    logic [N*W-1:0] core_solution = '0;
    logic [N-1:0]   core_load;
    logic [W-1:0]   core_base, solution, next_nonce;
    logic           core_abort, found, running, exhausted, irq;

    // 1-core instance
    logic           run_s = 1'b0;
    logic [W-1:0]   start_s = '0;
    logic [0:0]     ready_s = '0, found_s = '0;
    logic [W-1:0]   sol_in_s = '0;
    logic [0:0]     load_s;
    logic [W-1:0]   base_s, sol_s, next_s;
    logic           abort_s, found_o_s, running_s, exh_s, irq_s;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;   // model of the round-robin pointer

    miner_nonce_scheduler #(.NUM_CORES(N), .BATCH_LOG2(BL), .NONCE_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .start_nonce(start_nonce),
        .core_ready(core_ready), .core_found(core_found), .core_solution(core_solution),
        .core_load(core_load), .core_base(core_base), .core_abort(core_abort),
        .solution(solution), .found(found), .running(running), .exhausted(exhausted),
        .next_nonce(next_nonce), .irq(irq));

    miner_nonce_scheduler #(.NUM_CORES(1), .BATCH_LOG2(BL), .NONCE_W(W)) dut1 (
        .clk(clk), .rst_n(rst_n), .run(run_s), .start_nonce(start_s),
        .core_ready(ready_s), .core_found(found_s), .core_solution(sol_in_s),
        .core_load(load_s), .core_base(base_s), .core_abort(abort_s),
        .solution(sol_s), .found(found_o_s), .running(running_s), .exhausted(exh_s),
        .next_nonce(next_s), .irq(irq_s));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first set bit at or after p, wrapping.
    function automatic int rr_first(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic rand_solutions();
        for (int i = 0; i < N * W / 32; i++) core_solution[i*32 +: 32] = $urandom;
    endtask

    task automatic test_reset();
        run = 1'b1;   // held high across reset release: must not start a job
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if ({core_load, core_base, core_abort, solution, found, running, exhausted, next_nonce, irq} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got load=%h base=%h sol=%h nxt=%h flags=%b%b%b%b%b want all zero",
                     core_load, core_base, solution, next_nonce, core_abort, found, running, exhausted, irq);
        end
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            checks++;
            if (running !== 1'b0 || core_load !== '0) begin
                errors++;
                $display("FAIL reset_run_level got running=%b load=%h want 0 0", running, core_load);
            end
        end
        run = 1'b0;
        repeat (2) tick();
        m_ptr = 0;
    endtask

    task automatic test_basic_dispatch();
        start_nonce = 64'h100;
        core_ready  = 4'hF;
        run = 1'b1;
        tick();
        checks++;
        if (running !== 1'b1 || core_load !== '0) begin
            errors++;
            $display("FAIL basic_start got running=%b load=%h want 1 0", running, core_load);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (core_load !== 4'(1 << k) || core_base !== 64'h100 + 64'(k) * BATCH) begin
                errors++;
                $display("FAIL basic_load%0d got load=%h base=%h want %h %h",
                         k, core_load, core_base, 4'(1 << k), 64'h100 + 64'(k) * BATCH);
            end
            m_ptr = (k + 1) % N;
        end
        core_ready = '0;
        checks++;
        if (next_nonce !== 64'h140) begin
            errors++;
            $display("FAIL basic_next got %h want %h", next_nonce, 64'h140);
        end
    endtask

    task automatic test_found();
        rand_solutions();
        core_solution[2*W +: W] = 64'hDEADBEEF_00000123;
        core_found = 4'b0100;
        core_ready = 4'hF;
        tick();
        checks++;
        if (found !== 1'b1 || solution !== 64'hDEADBEEF_00000123 || irq !== 1'b1 || core_abort !== 1'b1
            || running !== 1'b0 || core_load !== '0) begin
            errors++;
            $display("FAIL found_hit got found=%b sol=%h irq=%b abort=%b run=%b load=%h want 1 deadbeef00000123 1 1 0 0",
                     found, solution, irq, core_abort, running, core_load);
        end
        repeat (3) begin
            tick();
            checks++;
            if (irq !== 1'b0 || core_abort !== 1'b0 || core_load !== '0 || found !== 1'b1) begin
                errors++;
                $display("FAIL found_hold got irq=%b abort=%b load=%h found=%b want 0 0 0 1",
                         irq, core_abort, core_load, found);
            end
        end
        core_found = '0;
        core_ready = '0;
        run = 1'b0;
        tick();
        checks++;
        if (found !== 1'b1 || running !== 1'b0 || solution !== 64'hDEADBEEF_00000123) begin
            errors++;
            $display("FAIL found_idle got found=%b running=%b sol=%h want 1 0 deadbeef00000123", found, running, solution);
        end
        tick();
    endtask

    task automatic test_simultaneous_found();
        int g;
        logic [W-1:0] exp_sol;
        start_nonce = {$urandom, $urandom};
        core_ready = 4'b0010;
        run = 1'b1;
        tick();
        tick();
        g = rr_first(4'b0010, m_ptr);
        checks++;
        if (core_load !== 4'(1 << g)) begin
            errors++;
            $display("FAIL simul_load got %h want %h", core_load, 4'(1 << g));
        end
        m_ptr = (g + 1) % N;
        core_ready = '0;
        rand_solutions();
        core_found = 4'b1010;
        g = rr_first(4'b1010, m_ptr);
        exp_sol = core_solution[g*W +: W];
        tick();
        checks++;
        if (g != 3 || solution !== exp_sol || found !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL simul_winner got sol=%h found=%b irq=%b want %h 1 1 (core %0d)",
                     solution, found, irq, exp_sol, g);
        end
        core_found = '0;
        run = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_exhaustion();
        logic [N-1:0] last = '0;
        int g;
        start_nonce = 64'hFFFF_FFFF_FFFF_FFE0;
        core_ready = 4'hF;
        run = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            g = rr_first(core_ready & ~last, m_ptr);
            checks++;
            if (core_load !== 4'(1 << g) || core_base !== 64'hFFFF_FFFF_FFFF_FFE0 + 64'(k) * BATCH) begin
                errors++;
                $display("FAIL exh_load%0d got load=%h base=%h want %h %h", k, core_load, core_base,
                         4'(1 << g), 64'hFFFF_FFFF_FFFF_FFE0 + 64'(k) * BATCH);
            end
            m_ptr = (g + 1) % N;
            last = 4'(1 << g);
        end
        checks++;
        if (next_nonce !== '0 || running !== 1'b1 || found !== 1'b0) begin
            errors++;
            $display("FAIL exh_drain got nxt=%h running=%b found=%b want 0 1 0", next_nonce, running, found);
        end
        core_ready = 4'b0111;
        repeat (3) begin
            tick();
            checks++;
            if (core_load !== '0 || running !== 1'b1 || exhausted !== 1'b0) begin
                errors++;
                $display("FAIL exh_wait got load=%h running=%b exh=%b want 0 1 0", core_load, running, exhausted);
            end
        end
        core_ready = 4'hF;
        tick();
        checks++;
        if (exhausted !== 1'b1 || running !== 1'b0 || irq !== 1'b0 || core_abort !== 1'b0 || core_load !== '0) begin
            errors++;
            $display("FAIL exh_done got exh=%b running=%b irq=%b abort=%b load=%h want 1 0 0 0 0",
                     exhausted, running, irq, core_abort, core_load);
        end
        run = 1'b0;
        core_ready = '0;
        repeat (2) tick();
    endtask

    task automatic test_random_jobs();
        for (int job = 0; job < 8; job++) begin
            logic [N-1:0] last = '0;
            logic [W-1:0] exp_next;
            int len;
            int g;
            start_nonce = {1'b0, 31'($urandom), $urandom};
            exp_next = start_nonce;
            core_ready = 4'($urandom_range(0, 15));
            run = 1'b1;
            tick();
            checks++;
            if (running !== 1'b1 || core_load !== '0 || exhausted !== 1'b0) begin
                errors++;
                $display("FAIL rand_start%0d got running=%b load=%h exh=%b want 1 0 0", job, running, core_load, exhausted);
            end
            len = $urandom_range(5, 20);
            for (int c = 0; c < len; c++) begin
                logic [N-1:0] exp_load;
                logic [W-1:0] exp_base;
                core_ready = 4'($urandom_range(0, 15));
                g = rr_first(core_ready & ~last, m_ptr);
                tick();
                exp_load = '0;
                exp_base = core_base;
                if (g >= 0) begin
                    exp_load = 4'(1 << g);
                    exp_base = exp_next;
                    exp_next = exp_next + BATCH;
                    m_ptr = (g + 1) % N;
                end
                checks++;
                if (core_load !== exp_load || (g >= 0 && core_base !== exp_base) || next_nonce !== exp_next) begin
                    errors++;
                    $display("FAIL rand_dispatch%0d_%0d got load=%h base=%h nxt=%h want %h %h %h",
                             job, c, core_load, core_base, next_nonce, exp_load, exp_base, exp_next);
                end
                last = exp_load;
            end
            if (job % 2 == 0) begin
                logic [W-1:0] exp_sol;
                rand_solutions();
                core_found = 4'($urandom_range(1, 15));
                core_ready = 4'($urandom_range(0, 15));
                g = rr_first(core_found, m_ptr);
                exp_sol = core_solution[g*W +: W];
                tick();
                checks++;
                if (solution !== exp_sol || found !== 1'b1 || irq !== 1'b1 || core_abort !== 1'b1 || core_load !== '0) begin
                    errors++;
                    $display("FAIL rand_found%0d got sol=%h found=%b irq=%b abort=%b load=%h want %h 1 1 1 0",
                             job, solution, found, irq, core_abort, core_load, exp_sol);
                end
                core_found = '0;
                run = 1'b0;
                tick();
            end else begin
                run = 1'b0;
                tick();
                checks++;
                if (core_abort !== 1'b1 || running !== 1'b0 || found !== 1'b0 || core_load !== '0 || irq !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_abort%0d got abort=%b running=%b found=%b load=%h irq=%b want 1 0 0 0 0",
                             job, core_abort, running, found, core_load, irq);
                end
            end
            core_ready = '0;
            tick();
        end
    endtask

    task automatic test_abort_and_reset();
        start_nonce = 64'h0000_1234_5678_0000;
        core_ready = 4'hF;
        run = 1'b1;
        repeat (3) tick();
        run = 1'b0;
        tick();
        checks++;
        if (core_abort !== 1'b1 || running !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse got abort=%b running=%b found=%b exh=%b irq=%b want 1 0 0 0 0",
                     core_abort, running, found, exhausted, irq);
        end
        tick();
        checks++;
        if (core_abort !== 1'b0 || core_load !== '0) begin
            errors++;
            $display("FAIL abort_once got abort=%b load=%h want 0 0", core_abort, core_load);
        end
        // Mid-job asynchronous reset.
        run = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({core_load, core_base, core_abort, solution, found, running, exhausted, next_nonce, irq} !== '0) begin
            errors++;
            $display("FAIL async_reset got load=%h base=%h sol=%h nxt=%h running=%b want all zero",
                     core_load, core_base, solution, next_nonce, running);
        end
        run = 1'b0;
        core_ready = '0;
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
        repeat (2) tick();
    endtask

    task automatic test_single_core();
        logic last = 1'b0;
        logic [W-1:0] exp_next;
        int loads = 0;
        start_s = {$urandom, $urandom};
        exp_next = start_s;
        ready_s = 1'b1;
        run_s = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            logic exp_load;
            tick();
            exp_load = ready_s[0] & ~last;
            checks++;
            if (load_s !== exp_load || (exp_load && base_s !== exp_next)) begin
                errors++;
                $display("FAIL single_load%0d got load=%b base=%h want %b %h", k, load_s, base_s, exp_load, exp_next);
            end
            if (exp_load) begin
                exp_next = exp_next + BATCH;
                loads++;
            end
            last = exp_load;
        end
        checks++;
        if (loads != 4 || next_s !== exp_next) begin
            errors++;
            $display("FAIL single_count got loads=%0d nxt=%h want 4 %h", loads, next_s, exp_next);
        end
        run_s = 1'b0;
        tick();
        checks++;
        if (abort_s !== 1'b1 || running_s !== 1'b0) begin
            errors++;
            $display("FAIL single_abort got abort=%b running=%b want 1 0", abort_s, running_s);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_dispatch();
        test_found();
        test_simultaneous_found();
        test_exhaustion();
        test_random_jobs();
        test_abort_and_reset();
        test_single_core();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/miner_nonce_scheduler.md
Name: miner_nonce_scheduler

Overview:
- Sequences up to NUM_CORES sha3_256_miner cores that share one job.
- Hands out fixed-size nonce batches, round-robin among idle cores.
- On the first reported solution, latches it, aborts all cores and raises a one-cycle irq.
- Sits between the Avalon register file and the core array, in the miner clock domain.

Parameters:
NUM_CORES, 4, number of mining cores scheduled (1..16)
BATCH_LOG2, 16, log2 of nonces per batch (batch size = 2^BATCH_LOG2)
NONCE_W, 64, nonce width in bits

Ports:
clk  in  1  miner clock
rst_n  in  1  reset, asynchronous assert, active low
run  in  1  level run request; a rising edge starts a job
start_nonce  in  NONCE_W  first nonce of the job, sampled on the run rising edge
core_ready  in  NUM_CORES  core i idle and able to accept a batch
core_found  in  NUM_CORES  core i holds a solution (level, held until abort or load)
core_solution  in  NUM_CORES*NONCE_W  solution of core i, in slice i
core_load  out  NUM_CORES  one-hot, one-cycle batch load strobe
core_base  out  NONCE_W  batch base nonce, valid while core_load != 0
core_abort  out  1  one-cycle abort strobe to all cores
solution  out  NONCE_W  latched winning nonce
found  out  1  solution valid
running  out  1  job in progress
exhausted  out  1  nonce space ended with no solution
next_nonce  out  NONCE_W  next undispatched base (progress)
irq  out  1  one-cycle pulse on found

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; all outputs 0; run_d=0; rr_ptr=0; last_grant=0.
- run_d registers run every cycle. start = run & ~run_d.
- States: IDLE, DISPATCH, DRAIN, DONE. running=1 in DISPATCH and DRAIN only.
- IDLE:
  - On start: next_nonce<=start_nonce, found<=0, exhausted<=0, solution kept; go to DISPATCH next cycle.
  - A run level already high when reset releases does not start a job.
- DISPATCH / DRAIN, checked each cycle in this priority order:
  1. run==0: core_abort pulse, go to IDLE. found/exhausted unchanged.
  2. Any core_found:
     - Pick the winner round-robin from rr_ptr.
     - solution<=winner slice, found<=1, irq pulse, core_abort pulse, go to DONE.
     - No core_load in this cycle, even if a core is ready.
  3. DISPATCH only, with eligible = core_ready & ~last_grant nonzero:
     - Grant the first eligible index at or after rr_ptr (wrapping).
     - core_load[g]=1 for one cycle; core_base=next_nonce (registered outputs, same cycle as the strobe).
     - rr_ptr<=g+1 mod NUM_CORES.
     - next_nonce<=next_nonce+2^BATCH_LOG2, truncated to NONCE_W.
     - If that add carries out of NONCE_W, go to DRAIN (last batch issued).
  - last_grant<=core_load each cycle. It masks the granted core for one cycle, because core_ready may fall only one cycle after load.
  - DRAIN: if core_ready is all ones and last_grant==0, set exhausted<=1 and go to IDLE. No abort, no irq.
- DONE:
  - Hold solution/found. Ignore core_found and core_ready; issue no loads.
  - When run falls, go to IDLE. found stays 1 until the next start.
- Latency:
  - start to first core_load: 2 cycles, if a core is ready.
  - core_found to irq/found/core_abort: 1 cycle.
- Throughput: at most one load per cycle.
- Simultaneous found from several cores: only the round-robin winner is reported; the others are discarded by the abort.
- start with run already high in DONE is not possible: a falling edge is needed first.
- NUM_CORES==1: rr_ptr stays 0; last_grant forces a minimum of 2 cycles between loads.

Test Plan:
- Basic dispatch:
  - Stimulus: NUM_CORES=4, BATCH_LOG2=4, all ready, start_nonce=0x100, run rises.
  - Required: loads to cores 0,1,2,3 on consecutive cycles, core_base 0x100, 0x110, 0x120, 0x130; next_nonce=0x140.
- Found:
  - Stimulus: core 2 asserts core_found with solution 0xDEADBEEF_00000123.
  - Required: next cycle found=1, solution=0xDEADBEEF00000123, irq and core_abort high exactly one cycle; no further loads; running=0.
- Simultaneous found:
  - Stimulus: cores 1 and 3 found in the same cycle with rr_ptr=2.
  - Required: solution = core 3 slice.
- Exhaustion:
  - Stimulus: start_nonce=0xFFFF_FFFF_FFFF_FFE0, BATCH_LOG2=4.
  - Required: two loads (…FFE0, …FFF0); DRAIN entered; once all ready, exhausted=1, running=0, irq stays 0.
- Abort mid-job:
  - Stimulus: run drops during DISPATCH.
  - Required: one core_abort pulse, IDLE, found unchanged.
  - Then: rst_n low mid-job clears all outputs asynchronously, within the same cycle.
- Ready masking:
  - Stimulus: one core keeps ready high with NUM_CORES=1.
  - Required: loads at most every second cycle, base incrementing by 2^BATCH_LOG2.
